// File: rtl/add_32_arbiter.sv
// add_32_arbiter: round-robin scheduler sharing one 32-bit adder among N_REQ requesters.
// Latency: response valid 2 cycles after acceptance (narrow), 3 cycles (wide, two adder passes).
// Backpressure: one request in flight; response held in RESP until rsp_ready, no grants meanwhile.

module add_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_carry,
  output logic [31:0] o_sum,
  output logic        o_carry,
  output logic        o_overflow
);

  logic [32:0] w_full;

  assign w_full     = {1'b0, i_a} + {1'b0, i_b} + {32'b0, i_carry};
  assign o_sum      = w_full[31:0];
  assign o_carry    = w_full[32];
  assign o_overflow = (i_a[31] == i_b[31]) && (w_full[31] != i_a[31]);

endmodule

module add_32_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req_valid,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic [64*N_REQ-1:0]  i_req_a,
  input  logic [64*N_REQ-1:0]  i_req_b,
  input  logic [N_REQ-1:0]     i_req_wide,
  input  logic [N_REQ-1:0]     i_req_sub,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic [63:0]          o_rsp_sum,
  output logic                 o_rsp_carry,
  output logic                 o_rsp_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_ptr;
  logic [63:0]       r_a;
  logic [63:0]       r_b;
  logic              r_wide;
  logic              r_sub;
  logic [ID_W-1:0]   r_id;
  logic              r_lo_carry;
  logic [63:0]       r_sum;
  logic              r_carry;
  logic              r_ovf;

  logic              w_any;
  logic [ID_W-1:0]   w_win;
  logic [N_REQ-1:0]  w_grant;
  logic [63:0]       w_sel_a;
  logic [63:0]       w_sel_b;
  logic              w_sel_wide;
  logic              w_sel_sub;
  int                w_best;
  int                w_dist;

  logic              w_hi;
  logic [31:0]       w_add_a;
  logic [31:0]       w_b_word;
  logic [31:0]       w_add_b;
  logic              w_add_cin;
  logic [31:0]       w_add_sum;
  logic              w_add_cout;
  logic              w_unused_ovf;
  logic              w_ovf;

  // Pick the valid requester closest at-or-after the pointer (distance measured with wrap).
  always_comb begin
    w_any      = 1'b0;
    w_win      = '0;
    w_grant    = '0;
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_wide = 1'b0;
    w_sel_sub  = 1'b0;
    w_best     = N_REQ;
    w_dist     = 0;
    for (int j = 0; j < N_REQ; j++) begin
      w_dist = (j + N_REQ - int'(r_ptr)) % N_REQ;
      if (i_req_valid[j] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_any      = 1'b1;
        w_win      = ID_W'(j);
        w_grant    = '0;
        w_grant[j] = 1'b1;
        w_sel_a    = i_req_a[64*j +: 64];
        w_sel_b    = i_req_b[64*j +: 64];
        w_sel_wide = i_req_wide[j];
        w_sel_sub  = i_req_sub[j];
      end
    end
  end

  // State register; reset drops any in-flight request.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state plus the grant pulse and response valid.
  always_comb begin
    w_next      = r_state;
    o_req_ready = '0;
    o_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          o_req_ready = w_grant;
          w_next      = S_LO;
        end
      end
      S_LO:   w_next = r_wide ? S_HI : S_RESP;
      S_HI:   w_next = S_RESP;
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shared adder: low word first, high word second with the low-pass carry chained in.
  assign w_hi      = (r_state == S_HI);
  assign w_add_a   = w_hi ? r_a[63:32] : r_a[31:0];
  assign w_b_word  = w_hi ? r_b[63:32] : r_b[31:0];
  assign w_add_b   = r_sub ? ~w_b_word : w_b_word;
  assign w_add_cin = w_hi ? r_lo_carry : r_sub;
  assign w_ovf     = (w_add_a[31] == w_add_b[31]) && (w_add_sum[31] != w_add_a[31]);

  add_32 u_add (
    .i_a        (w_add_a),
    .i_b        (w_add_b),
    .i_carry    (w_add_cin),
    .o_sum      (w_add_sum),
    .o_carry    (w_add_cout),
    .o_overflow (w_unused_ovf)
  );

  // Capture the granted request, then accumulate the result one word per pass.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_wide     <= 1'b0;
      r_sub      <= 1'b0;
      r_id       <= '0;
      r_lo_carry <= 1'b0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a    <= w_sel_a;
            r_b    <= w_sel_b;
            r_wide <= w_sel_wide;
            r_sub  <= w_sel_sub;
            r_id   <= w_win;
            r_ptr  <= (int'(w_win) == N_REQ - 1) ? '0 : w_win + ID_W'(1);
          end
        end
        S_LO: begin
          r_sum[31:0] <= w_add_sum;
          r_lo_carry  <= w_add_cout;
          if (!r_wide) begin
            r_sum[63:32] <= '0;
            r_carry      <= w_add_cout;
            r_ovf        <= w_ovf;
          end
        end
        S_HI: begin
          r_sum[63:32] <= w_add_sum;
          r_carry      <= w_add_cout;
          r_ovf        <= w_ovf;
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_id       = r_id;
  assign o_rsp_sum      = r_sum;
  assign o_rsp_carry    = r_carry;
  assign o_rsp_overflow = r_ovf;

endmodule

// File: doc/add_32_arbiter.md
Name: add_32_arbiter

Overview:
- Round-robin scheduler that shares one add_32 ripple adder among N_REQ requesters.
- Each request is a 32-bit or 64-bit add or subtract. A 64-bit request runs as two adder passes, low word then high word, with the carry chained between them.
- Results go back on one response channel tagged with the requester index, using a valid/ready handshake.
- Sits between the ALU issue logic and the shared adder datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of the requester index; must satisfy 2**ID_W >= N_REQ

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  one-hot grant pulse; the request is accepted when valid && ready
req_a  in  64*N_REQ  operand A; requester i uses bits [64i+63:64i]
req_b  in  64*N_REQ  operand B; same packing as req_a
req_wide  in  N_REQ  1 = 64-bit operation, 0 = 32-bit (low words only)
req_sub  in  N_REQ  1 = A - B, 0 = A + B
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted by consumer
rsp_id  out  ID_W  index of the requester that was served
rsp_sum  out  64  result; upper 32 bits are zero for narrow operations
rsp_carry  out  1  carry out of the top bit (for subtract: 1 = no borrow)
rsp_overflow  out  1  signed two's-complement overflow

Behaviour:
- Reset values: rsp_valid=0, req_ready=0, rsp_id=0, rsp_sum=0, rsp_carry=0, rsp_overflow=0. FSM goes to IDLE. Round-robin pointer = 0.
- Reset mid-operation: the in-flight request is dropped with no response. The requester must re-request.
- One add_32 instance is used for both passes.
  - Adder b input = sub ? ~B_word : B_word.
  - Pass LO: i_carry = sub.
  - Pass HI: i_carry = registered carry out of pass LO.
  - The add_32 overflow port is not used.
- Signed overflow: computed on the top word of the operation as (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the possibly inverted B word.
- FSM states: IDLE, LO, HI, RESP.
  - IDLE: if any req_valid is set, grant the first valid requester at or after the pointer, searching upward with wrap. req_ready is asserted combinationally to the winner only, for this cycle only. Capture a, b, wide, sub and id. Set pointer = winner+1 mod N_REQ. Go to LO. If no request is valid, stay in IDLE and set no req_ready bit.
  - LO: register low sum and carry. If wide, go to HI. Otherwise register carry and overflow from bit 31, zero the upper sum bits, and go to RESP.
  - HI: register high sum, carry and overflow from bit 63. Go to RESP.
  - RESP: rsp_valid=1 with all rsp_* stable. Leave to IDLE on the rsp_valid && rsp_ready cycle.
- Latency, with acceptance in cycle T:
  - Narrow: rsp_valid first high at T+2.
  - Wide: rsp_valid first high at T+3.
  - Back-to-back: a new grant is possible in the cycle after the response handshake.
- Only one request is in flight at a time. req_ready stays 0 in LO, HI and RESP.
- Requesters that are not granted hold req_valid. A requester may drop req_valid before it is granted without side effects.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0.
- rsp_ready held low leaves the FSM in RESP indefinitely with outputs held; no new grant is issued.

Test Plan:
- Reset: assert rst mid-HI on a wide add -> next cycle rsp_valid=0, req_ready=0. The following grant goes to requester 0 when req0 and req1 are both valid.
- Narrow add: req0, a=0xFFFFFFFF, b=1, rsp_ready=1 -> rsp_valid at T+2 with sum=0x0000000000000000, carry=1, overflow=0, id=0.
- Narrow signed overflow: req2, a=0x7FFFFFFF, b=1 -> sum=0x0000000080000000, carry=0, overflow=1, id=2.
- Wide add with chained carry: req1, a=0x00000000FFFFFFFF, b=1, wide=1 -> rsp_valid at T+3 with sum=0x0000000100000000, carry=0, overflow=0.
- Wide subtract: req3, a=0, b=1, wide=1, sub=1 -> sum=0xFFFFFFFFFFFFFFFF, carry=0 (borrow), overflow=0. Then a=0x8000000000000000, b=1 -> sum=0x7FFFFFFFFFFFFFFF, overflow=1.
- Arbitration and backpressure: all four requesters valid, rsp_ready held 0 for 5 cycles then 1 -> rsp_valid and outputs held stable while stalled, no req_ready during the stall, grant order 0,1,2,3,0.
